// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA sync/blank/address generator with delayed outputs.
// Define VGA_TIMING_PATTERN_EN to add the pat_r/pat_g/pat_b colour-bar outputs.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int CNT_W = 11,
  parameter int ADDR_W = 19,
  parameter int PIPE_DLY = 1
) (
  input  logic              pixel_clk,
  input  logic              rst,
  input  logic              en,
  output logic [CNT_W-1:0]  hcount,
  output logic [CNT_W-1:0]  vcount,
  output logic [ADDR_W-1:0] addr,
  output logic              hs,
  output logic              vs,
  output logic              blank,
  output logic              active,
  output logic              line_start,
  output logic              frame_start
`ifdef VGA_TIMING_PATTERN_EN
  ,
  output logic [3:0]        pat_r,
  output logic [3:0]        pat_g,
  output logic [3:0]        pat_b
`endif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
`ifdef VGA_TIMING_PATTERN_EN
  localparam int PW = 17;
  localparam logic [CNT_W+2:0] H_ACT_W = (CNT_W+3)'(H_ACTIVE);
`else
  localparam int PW = 5;
`endif
  logic h_wrap, v_wrap, h_vis, v_vis, hs_raw, vs_raw, blank_raw;
  logic [4:0] base;
  logic [PW-1:0] raw, rst_val;
  logic [PW-1:0] pipe [PIPE_DLY];
  assign h_wrap = hcount == H_LAST;
  assign v_wrap = vcount == V_LAST;
  assign h_vis = hcount < H_VIS;
  assign v_vis = vcount < V_VIS;
  assign hs_raw = (hcount >= HS_BEG && hcount < HS_END) ? HS_POL : ~HS_POL;
  assign vs_raw = (vcount >= VS_BEG && vcount < VS_END) ? VS_POL : ~VS_POL;
  assign blank_raw = ~(h_vis & v_vis);
  assign base = {hcount == '0 && vcount == '0, hcount == '0, blank_raw, vs_raw, hs_raw};
  assign rst_val = PW'({1'b0, 1'b0, 1'b1, ~VS_POL, ~HS_POL});
`ifdef VGA_TIMING_PATTERN_EN
  logic [2:0] bar;
  assign bar = 3'({hcount, 3'b000} / H_ACT_W);
  assign raw = {blank_raw ? 12'h000 : {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}}, base};
  assign {pat_r, pat_g, pat_b, frame_start, line_start, blank, vs, hs} = pipe[PIPE_DLY-1];
`else
  assign raw = base;
  assign {frame_start, line_start, blank, vs, hs} = pipe[PIPE_DLY-1];
`endif
  assign active = ~blank;
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      hcount <= '0;
      vcount <= '0;
      addr <= '0;
    end else if (en) begin
      hcount <= h_wrap ? '0 : hcount + CNT_W'(1);
      vcount <= h_wrap ? (v_wrap ? '0 : vcount + CNT_W'(1)) : vcount;
      addr <= (h_wrap && v_wrap) ? '0 : (h_vis && v_vis) ? addr + ADDR_W'(1) : addr;
    end
  end
  // stage 0 captures the raw decode; later stages shift only on enabled cycles
  always_ff @(posedge pixel_clk) begin
    for (int i = 0; i < PIPE_DLY; i++)
      if (rst) pipe[i] <= rst_val;
      else if (en) pipe[i] <= (i == 0) ? raw : pipe[(i == 0) ? 0 : i - 1];
  end
endmodule
